// File: rtl/vec_deser_i8.sv
// vec_deser_i8: stream-to-vector deserializer feeding the vec_sum_i8 reduction tree.
// Signed elements arrive one per cycle on a valid/ready handshake and are packed,
// first-received at index 0, into a `length`-element vector that is offered on a
// second valid/ready handshake. A vector that completes while the output register
// is still occupied is parked in the assembly buffer (pending) until it drains.
// Optional feature macro: VEC_DESER_SUM_EN adds a running accumulator and o_sum,
// the sum of the vector currently presented on o_vec.
module vec_deser_i8 #(
    parameter int bit_width = 16,
    parameter int length    = 32,
`ifdef VEC_DESER_SUM_EN
    parameter int sum_width = bit_width + $clog2(length),
`endif
    parameter int cnt_width = $clog2(length)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_elem_valid,
    output logic                        o_elem_ready,
    input  logic signed [bit_width-1:0] i_elem,
    input  logic                        i_flush,
    output logic                        o_vec_valid,
    input  logic                        i_vec_ready,
`ifdef VEC_DESER_SUM_EN
    output logic signed [sum_width-1:0] o_sum,
`endif
    output logic signed [bit_width-1:0] o_vec [length]
);

    localparam logic [cnt_width-1:0] last_idx = cnt_width'(length - 1);

    logic [cnt_width-1:0]        idx_q,       idx_d;
    logic                        pending_q,   pending_d;
    logic                        vec_valid_q, vec_valid_d;
    logic                        rdy_q,       rdy_d;
    logic signed [bit_width-1:0] asm_q [length];
    logic signed [bit_width-1:0] asm_d [length];
    logic signed [bit_width-1:0] vec_q [length];
    logic signed [bit_width-1:0] vec_d [length];

    logic elem_ready_s;
    logic accept_s;
    logic last_s;
    logic out_free_s;
    logic load_direct_s;
    logic load_pend_s;

`ifdef VEC_DESER_SUM_EN
    logic signed [sum_width-1:0] acc_q,  acc_d;
    logic signed [sum_width-1:0] psum_q, psum_d;
    logic signed [sum_width-1:0] sum_q,  sum_d;
    logic signed [sum_width-1:0] elem_ext_s;
    logic signed [sum_width-1:0] acc_next_s;
`endif

    // Handshake qualifiers; rdy_q keeps the input closed until the first edge after reset.
    always_comb begin
        elem_ready_s  = rdy_q & ~pending_q & ~i_flush;
        accept_s      = i_elem_valid & elem_ready_s;
        last_s        = (idx_q == last_idx);
        out_free_s    = ~vec_valid_q | i_vec_ready;
        load_direct_s = accept_s & last_s & out_free_s;
        load_pend_s   = pending_q & out_free_s;
    end

    // Next-state for index, assembly buffer, output vector, valid and pending flag.
    always_comb begin
        rdy_d       = 1'b1;
        idx_d       = idx_q;
        asm_d       = asm_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;
        pending_d   = pending_q;

        if (i_flush) begin
            idx_d = '0;
        end else if (accept_s) begin
            idx_d = idx_q + cnt_width'(1);
        end else begin
            idx_d = idx_q;
        end

        if (accept_s) begin
            asm_d[idx_q] = i_elem;
        end else begin
            asm_d = asm_q;
        end

        if (load_direct_s) begin
            // Bypass the last element straight into the output register.
            vec_d             = asm_q;
            vec_d[length-1]   = i_elem;
            vec_valid_d       = 1'b1;
            pending_d         = pending_q;
        end else if (load_pend_s) begin
            vec_d       = asm_q;
            vec_valid_d = 1'b1;
            pending_d   = 1'b0;
        end else begin
            vec_d = vec_q;
            if (vec_valid_q & i_vec_ready) begin
                vec_valid_d = 1'b0;
            end else begin
                vec_valid_d = vec_valid_q;
            end
            // Completion while the output is occupied parks the vector in asm.
            if (accept_s & last_s) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_q;
            end
        end
    end

`ifdef VEC_DESER_SUM_EN
    // Running sum; the completed total follows the same direct/pending path as the vector.
    always_comb begin
        elem_ext_s = {{(sum_width - bit_width){i_elem[bit_width-1]}}, i_elem};
        acc_next_s = acc_q + elem_ext_s;
        acc_d      = acc_q;
        psum_d     = psum_q;
        sum_d      = sum_q;

        if (i_flush) begin
            acc_d = '0;
        end else if (accept_s) begin
            if (last_s) begin
                acc_d = '0;
                if (out_free_s) begin
                    sum_d = acc_next_s;
                end else begin
                    psum_d = acc_next_s;
                end
            end else begin
                acc_d = acc_next_s;
            end
        end else begin
            acc_d = acc_q;
        end

        if (load_pend_s) begin
            sum_d = psum_q;
        end else begin
            sum_d = sum_d;
        end
    end
`endif

    // State registers; reset clears everything and drops o_vec_valid immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q       <= '0;
            pending_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
            asm_q       <= '{default: '0};
            vec_q       <= '{default: '0};
`ifdef VEC_DESER_SUM_EN
            acc_q       <= '0;
            psum_q      <= '0;
            sum_q       <= '0;
`endif
        end else begin
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            vec_valid_q <= vec_valid_d;
            rdy_q       <= rdy_d;
            asm_q       <= asm_d;
            vec_q       <= vec_d;
`ifdef VEC_DESER_SUM_EN
            acc_q       <= acc_d;
            psum_q      <= psum_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign o_elem_ready = elem_ready_s;
    assign o_vec_valid  = vec_valid_q;
    assign o_vec        = vec_q;
`ifdef VEC_DESER_SUM_EN
    assign o_sum        = sum_q;
`endif

endmodule

// File: tb/tb_vec_deser_i8.sv
// Testbench for vec_deser_i8 (length=4, bit_width=8). A negedge monitor keeps a
// reference model of accepted elements, pushes each completed vector into a
// scoreboard queue and compares it when the DUT hands a vector downstream.
// Directed sequences add timing, ready and reset checks; VEC_DESER_SUM_EN also checks o_sum.
module tb_vec_deser_i8;

    localparam int BW = 8;
    localparam int LN = 4;
`ifdef VEC_DESER_SUM_EN
    localparam int SW = BW + $clog2(LN);
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 i_elem_valid;
    logic                 o_elem_ready;
    logic signed [BW-1:0] i_elem;
    logic                 i_flush;
    logic                 o_vec_valid;
    logic                 i_vec_ready;
    logic signed [BW-1:0] o_vec [LN];
`ifdef VEC_DESER_SUM_EN
    logic signed [SW-1:0] o_sum;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    int pop_cnt = 0;

    logic [31:0] exp_vec_q [$];
`ifdef VEC_DESER_SUM_EN
    int          exp_sum_q [$];
`endif

    vec_deser_i8 #(.bit_width(BW), .length(LN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_elem_valid (i_elem_valid),
        .o_elem_ready (o_elem_ready),
        .i_elem       (i_elem),
        .i_flush      (i_flush),
        .o_vec_valid  (o_vec_valid),
        .i_vec_ready  (i_vec_ready),
`ifdef VEC_DESER_SUM_EN
        .o_sum        (o_sum),
`endif
        .o_vec        (o_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [7:0] a8, b8, c8, d8;
        a8 = a[7:0];
        b8 = b[7:0];
        c8 = c[7:0];
        d8 = d[7:0];
        return {d8, c8, b8, a8};
    endfunction

    function automatic logic [31:0] cur_vec();
        return {o_vec[3], o_vec[2], o_vec[1], o_vec[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_elem_valid = 1'b0;
        i_vec_ready  = 1'b1;
        i_flush      = 1'b0;
        repeat (n) step();
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    initial begin
        logic [7:0]  part [LN];
        int          pcnt;
        int          psum;
        logic        prev_hold;
        logic [31:0] prev_vec;
        logic [31:0] cur;
        logic [31:0] ev;
        pcnt = 0;
        psum = 0;
        prev_hold = 1'b0;
        prev_vec = '0;
        forever begin
            @(negedge clk);
            cur = cur_vec();
            if (!rst_n) begin
                exp_vec_q.delete();
`ifdef VEC_DESER_SUM_EN
                exp_sum_q.delete();
`endif
                pcnt = 0;
                psum = 0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) check_val("hold_stable", cur, prev_vec);
                if (o_vec_valid && i_vec_ready) begin
                    check_val("sb_nonempty", longint'(exp_vec_q.size() > 0), 1);
                    if (exp_vec_q.size() > 0) begin
                        ev = exp_vec_q.pop_front();
                        check_val("sb_vec", cur, ev);
`ifdef VEC_DESER_SUM_EN
                        check_val("sb_sum", int'(o_sum), exp_sum_q.pop_front());
`endif
                        pop_cnt++;
                    end
                end
                if (i_flush) begin
                    pcnt = 0;
                    psum = 0;
                end else if (i_elem_valid && o_elem_ready) begin
                    part[pcnt] = i_elem;
                    psum += int'(i_elem);
                    pcnt++;
                    if (pcnt == LN) begin
                        exp_vec_q.push_back(pk(int'(part[0]), int'(part[1]), int'(part[2]), int'(part[3])));
`ifdef VEC_DESER_SUM_EN
                        exp_sum_q.push_back(psum);
`endif
                        pcnt = 0;
                        psum = 0;
                    end
                end
                prev_hold = o_vec_valid && !i_vec_ready;
                prev_vec  = cur;
            end
        end
    end

    initial begin
        int t3 [4];
        int target;
        int cyc;
        t3 = '{-128, 127, -1, 0};

        rst_n        = 1'b0;
        i_elem_valid = 1'b0;
        i_elem       = '0;
        i_flush      = 1'b0;
        i_vec_ready  = 1'b1;

        // Reset state
        repeat (2) step();
        check_val("rst_ready", o_elem_ready, 0);
        check_val("rst_valid", o_vec_valid, 0);
        check_val("rst_vec", cur_vec(), 0);
        #2 rst_n = 1'b1;
        step();
        check_val("rel_ready", o_elem_ready, 1);

        // Streaming 1..8 with downstream always ready
        for (int k = 0; k < 8; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(k + 1);
            #1;
            check_val("t1_ready", o_elem_ready, 1);
            step();
            check_val("t1_valid", o_vec_valid, longint'(k == 3 || k == 7));
            if (k == 3) check_val("t1_vec0", cur_vec(), pk(1, 2, 3, 4));
            if (k == 7) check_val("t1_vec1", cur_vec(), pk(5, 6, 7, 8));
        end
        idle(3);

        // Downstream stalled: second vector goes pending
        i_vec_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(k + 1);
            #1;
            check_val("t2_ready", o_elem_ready, 1);
            step();
        end
        i_elem_valid = 1'b0;
        #1;
        check_val("t2_ready_pend", o_elem_ready, 0);
        check_val("t2_valid_hold", o_vec_valid, 1);
        check_val("t2_vec_hold", cur_vec(), pk(1, 2, 3, 4));
        i_vec_ready = 1'b1;
        #1;
        check_val("t2_ready_drain", o_elem_ready, 0);
        step();
        i_vec_ready = 1'b0;
        #1;
        check_val("t2_vec_pend", cur_vec(), pk(5, 6, 7, 8));
        check_val("t2_valid_pend", o_vec_valid, 1);
        check_val("t2_ready_back", o_elem_ready, 1);
        idle(3);

        // Signed extremes
        for (int k = 0; k < 4; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(t3[k]);
            step();
        end
        i_elem_valid = 1'b0;
        check_val("t3_valid", o_vec_valid, 1);
        check_val("t3_vec", cur_vec(), pk(-128, 127, -1, 0));
`ifdef VEC_DESER_SUM_EN
        check_val("t3_sum", int'(o_sum), -2);
`endif
        idle(3);

        // Flush discards a partial vector
        for (int k = 0; k < 2; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(100 + k);
            step();
        end
        i_flush = 1'b1;
        i_elem  = 8'd55;
        #1;
        check_val("t4_ready_flush", o_elem_ready, 0);
        step();
        i_flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(9 + k);
            step();
        end
        i_elem_valid = 1'b0;
        check_val("t4_valid", o_vec_valid, 1);
        check_val("t4_vec", cur_vec(), pk(9, 10, 11, 12));
        idle(3);

        // Asynchronous reset mid-vector with a vector held on the output
        i_vec_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(31 + k);
            step();
        end
        i_elem_valid = 1'b0;
        check_val("t5_valid_pre", o_vec_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_valid_rst", o_vec_valid, 0);
        check_val("t5_vec_rst", cur_vec(), 0);
        check_val("t5_ready_rst", o_elem_ready, 0);
        step();
        step();
        #1 rst_n = 1'b1;
        i_vec_ready = 1'b1;
        step();
        check_val("t5_ready_rel", o_elem_ready, 1);
        for (int k = 0; k < 4; k++) begin
            i_elem_valid = 1'b1;
            i_elem       = 8'(41 + k);
            step();
        end
        i_elem_valid = 1'b0;
        check_val("t5_vec_after", cur_vec(), pk(41, 42, 43, 44));
        idle(3);

        // Random valid/ready/flush traffic for 1000 vectors
        target = pop_cnt + 1000;
        cyc    = 0;
        while (pop_cnt < target && cyc < 40000) begin
            i_elem_valid = ($urandom_range(0, 9) < 7);
            i_elem       = 8'($urandom_range(0, 255));
            i_vec_ready  = 1'($urandom_range(0, 1));
            i_flush      = ($urandom_range(0, 63) == 0);
            step();
            cyc++;
        end
        check_val("rand_done", longint'(pop_cnt >= target), 1);
        idle(10);
        check_val("sb_drained", exp_vec_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
